mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage -- MEM pipeline stage with a two-state data-memory access FSM.
//
// Non-memory instructions pass through to the MEM/WB registers in one cycle.
// Loads and stores are latched, the stage enters ACCESS and drives the
// data-memory request until dm_ack, holding the upstream stages with freeze.
// When MEM_R and MEM_W are both set, the access is performed as a read.
//
// Build option:
//   MEM_ADDR_REBASE_EN  when defined, dm_addr = (ALU_res - 1024)[31:2];
//                       otherwise dm_addr = ALU_res[31:2].
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   valid, WB_EN, MEM_R, MEM_W      instruction present / control from EXE
//   ALU_res [31:0]                  EXE result, also the memory byte address
//   val_rm [31:0]                   store data
//   dest [3:0]                      destination register index
//   dm_req, dm_we                   data-memory request / write enable
//   dm_addr [29:0], dm_wdata [31:0] data-memory word address / store data
//   dm_rdata [31:0], dm_ack         data-memory load data / completion
//   freeze                          stall request to upstream stages
//   valid_out, WB_EN_out, MEM_R_out registered MEM/WB control
//   ALU_res_out, mem_data_out       registered MEM/WB data
//   dest_out [3:0]                  registered MEM/WB destination
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        WB_EN,
  input  logic        MEM_R,
  input  logic        MEM_W,
  input  logic [31:0] ALU_res,
  input  logic [31:0] val_rm,
  input  logic [3:0]  dest,
  output logic        dm_req,
  output logic        dm_we,
  output logic [29:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        freeze,
  output logic        valid_out,
  output logic        WB_EN_out,
  output logic        MEM_R_out,
  output logic [31:0] ALU_res_out,
  output logic [31:0] mem_data_out,
  output logic [3:0]  dest_out
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Operation captured when a memory instruction is accepted.
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_dest;
  logic        lat_wb;
  logic        lat_rd;
  logic        lat_wr;

  logic        accept;
  logic        complete;
  logic [29:0] word_addr;

`ifdef MEM_ADDR_REBASE_EN
  // Subtracting 1024 never touches bits [1:0], so rebasing the word address
  // by 256 gives (lat_addr - 1024)[31:2] modulo 2^30.
  assign word_addr = lat_addr[31:2] - 30'd256;
`else
  assign word_addr = lat_addr[31:2];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    complete  = 1'b0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    freeze    = 1'b0;
    case (state)
      IDLE: begin
        // freeze is gated by rst so it reads 0 for the whole reset pulse.
        accept = valid & (MEM_R | MEM_W) & ~rst;
        freeze = accept;
        if (accept) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        complete = dm_ack;
        dm_req   = 1'b1;
        dm_we    = lat_wr & ~lat_rd;
        dm_addr  = word_addr;
        dm_wdata = lat_wdata;
        freeze   = ~dm_ack;
        if (dm_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_dest     <= '0;
      lat_wb       <= 1'b0;
      lat_rd       <= 1'b0;
      lat_wr       <= 1'b0;
      valid_out    <= 1'b0;
      WB_EN_out    <= 1'b0;
      MEM_R_out    <= 1'b0;
      ALU_res_out  <= '0;
      mem_data_out <= '0;
      dest_out     <= '0;
    end else begin
      valid_out <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          lat_addr  <= ALU_res;
          lat_wdata <= val_rm;
          lat_dest  <= dest;
          lat_wb    <= WB_EN;
          lat_rd    <= MEM_R;
          lat_wr    <= MEM_W;
        end else if (valid) begin
          valid_out    <= 1'b1;
          WB_EN_out    <= WB_EN;
          MEM_R_out    <= 1'b0;
          ALU_res_out  <= ALU_res;
          mem_data_out <= '0;
          dest_out     <= dest;
        end
      end else if (complete) begin
        valid_out    <= 1'b1;
        WB_EN_out    <= lat_wb;
        MEM_R_out    <= lat_rd;
        ALU_res_out  <= lat_addr;
        mem_data_out <= lat_rd ? dm_rdata : '0;
        dest_out     <= lat_dest;
      end
    end
  end

endmodule
